// File: rtl/mem_stage.sv
// mem_stage: memory stage of the RV32I pipeline, between EX/MEM and MEM/WB.
// It issues at most one data-memory request per instruction. It holds the
// pipeline while that request is outstanding. When the response arrives, it
// formats the load data and registers the MEM/WB record.
//
//   state  | meaning
//   S_IDLE | nothing outstanding; a new access is issued from here
//   S_WAIT | request issued, waiting for the dmem_resp pulse
//
// ex_mem_reg layout, MSB first (291 bits):
//   valid, inst[32], pc[32], pc_next[32], rd_s[5], rs1_s[5], rs2_s[5],
//   rs1_v[32], rs2_v[32], regf_we, opcode[7], funct3[3], alu_result[32],
//   mem_addr[32], mem_rmask[4], mem_wmask[4], mem_wdata[32]
// mem_wb_reg layout, MSB first (313 bits):
//   valid, inst[32], pc[32], pc_next[32], rd_s[5], rs1_s[5], rs2_s[5],
//   rs1_v[32], rs2_v[32], regf_we, rd_v[32], mem_addr[32], mem_rmask[4],
//   mem_wmask[4], mem_rdata[32], mem_wdata[32]

module mem_stage #(
  parameter int MAX_WAIT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [290:0] ex_mem_reg,
  output logic [31:0]  dmem_addr,
  output logic [3:0]   dmem_rmask,
  output logic [3:0]   dmem_wmask,
  output logic [31:0]  dmem_wdata,
  input  logic [31:0]  dmem_rdata,
  input  logic         dmem_resp,
  output logic         mem_stall,
  output logic         mem_err,
  output logic [312:0] mem_wb_reg
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  // One spare bit so the counter can sit at MAX_WAIT without wrapping.
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 2);
  localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WAIT);

  logic        em_valid;
  logic [31:0] em_inst;
  logic [31:0] em_pc;
  logic [31:0] em_pc_next;
  logic [4:0]  em_rd_s;
  logic [4:0]  em_rs1_s;
  logic [4:0]  em_rs2_s;
  logic [31:0] em_rs1_v;
  logic [31:0] em_rs2_v;
  logic        em_regf_we;
  logic [6:0]  em_opcode;
  logic [2:0]  em_funct3;
  logic [31:0] em_alu_result;
  logic [31:0] em_mem_addr;
  logic [3:0]  em_mem_rmask;
  logic [3:0]  em_mem_wmask;
  logic [31:0] em_mem_wdata;

  assign {em_valid, em_inst, em_pc, em_pc_next, em_rd_s, em_rs1_s, em_rs2_s,
          em_rs1_v, em_rs2_v, em_regf_we, em_opcode, em_funct3, em_alu_result,
          em_mem_addr, em_mem_rmask, em_mem_wmask, em_mem_wdata} = ex_mem_reg;

  logic             state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             access;
  logic             req;
  logic             done;
  logic             use_load;
  logic [1:0]       off;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_fmt;
  logic [31:0]      rd_v;
  logic [312:0]     wb_nxt;

  assign access  = em_valid && ((em_mem_rmask != 4'b0) || (em_mem_wmask != 4'b0));
  // Gating with rst_n keeps the bus quiet while reset is held, even if EX presents an access.
  assign req     = rst_n && (state == S_IDLE) && access;
  assign done    = (state == S_WAIT) && dmem_resp;
  assign cnt_inc = cnt + 1'b1;

  assign dmem_addr  = {em_mem_addr[31:2], 2'b00};
  assign dmem_rmask = req ? em_mem_rmask : 4'b0;
  assign dmem_wmask = req ? em_mem_wmask : 4'b0;
  assign dmem_wdata = em_mem_wdata;
  assign mem_stall  = (state == S_IDLE) ? req : !dmem_resp;

  // Extract the addressed byte/half from the returned word and extend it by funct3.
  always_comb begin
    off     = em_mem_addr[1:0];
    ld_byte = dmem_rdata[{off, 3'b000} +: 8];
    ld_half = dmem_rdata[{off[1], 4'b0000} +: 16];
    case (em_funct3)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'b0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'b0, ld_half};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  // Build the MEM/WB record; load data is only meaningful on the completing cycle.
  always_comb begin
    use_load = done && (em_opcode == OP_LOAD);
    rd_v     = use_load ? ld_fmt : em_alu_result;
    if ((em_rd_s == 5'd0) || !em_regf_we) begin
      rd_v = 32'b0;
    end
    wb_nxt = {em_valid, em_inst, em_pc, em_pc_next, em_rd_s, em_rs1_s, em_rs2_s,
              em_rs1_v, em_rs2_v, em_regf_we, rd_v, em_mem_addr, em_mem_rmask,
              em_mem_wmask, (use_load ? dmem_rdata : 32'b0), em_mem_wdata};
  end

  // Request FSM, wait counter and sticky watchdog flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (access) begin
            state <= S_WAIT;
          end
        end
        default: begin
          if (dmem_resp) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            if (cnt != '1) begin
              cnt <= cnt_inc;
            end
            // The watchdog only flags a stuck access; the access itself keeps waiting.
            if ((MAX_WAIT != 0) && (cnt_inc == MAX_W)) begin
              mem_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // MEM/WB register: pass-through when idle, bubble while waiting, one commit on response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wb_reg <= '0;
    end else if (state == S_IDLE) begin
      if (access) begin
        mem_wb_reg[312] <= 1'b0;
      end else begin
        mem_wb_reg <= wb_nxt;
      end
    end else if (dmem_resp) begin
      mem_wb_reg <= wb_nxt;
    end else begin
      mem_wb_reg[312] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus randomized instruction mix,
// checked against a field-level reference model.

module tb_mem_stage;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic        regf_we;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] mem_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } instr_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic         clk;
  logic         rst_n;
  logic [290:0] ex_mem_reg;
  logic [31:0]  dmem_addr;
  logic [3:0]   dmem_rmask;
  logic [3:0]   dmem_wmask;
  logic [31:0]  dmem_wdata;
  logic [31:0]  dmem_rdata;
  logic         dmem_resp;
  logic         mem_stall;
  logic         mem_err;
  logic [312:0] mem_wb_reg;

  int n_vec  = 0;
  int n_miss = 0;

  mem_stage #(.MAX_WAIT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_mem_reg (ex_mem_reg),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_stall  (mem_stall),
    .mem_err    (mem_err),
    .mem_wb_reg (mem_wb_reg)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [290:0] pack_em(input instr_t t);
    return {t.valid, t.inst, t.pc, t.pc_next, t.rd_s, t.rs1_s, t.rs2_s, t.rs1_v,
            t.rs2_v, t.regf_we, t.opcode, t.funct3, t.alu_result, t.mem_addr,
            t.rmask, t.wmask, t.wdata};
  endfunction

  // Reference load formatting with shifts and arithmetic on the raw word.
  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int unsigned o;
    int unsigned b;
    int unsigned h;
    o = int'(addr & 32'h3);
    b = (rdata >> (8 * o)) & 32'hFF;
    h = (rdata >> (16 * (o / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [312:0] exp_wb(input instr_t t, input bit completed,
                                          input logic [31:0] rdata);
    bit          is_ld;
    logic [31:0] rdv;
    is_ld = completed && (t.opcode == OP_LOAD);
    rdv   = is_ld ? load_val(t.funct3, t.mem_addr, rdata) : t.alu_result;
    if (t.rd_s == 5'd0 || !t.regf_we) rdv = 32'd0;
    return {t.valid, t.inst, t.pc, t.pc_next, t.rd_s, t.rs1_s, t.rs2_s, t.rs1_v,
            t.rs2_v, t.regf_we, rdv, t.mem_addr, t.rmask, t.wmask,
            (is_ld ? rdata : 32'd0), t.wdata};
  endfunction

  function automatic instr_t base_instr();
    instr_t t;
    t.valid      = 1'b1;
    t.inst       = $urandom;
    t.pc         = $urandom & 32'hFFFF_FFFC;
    t.pc_next    = t.pc + 32'd4;
    t.rd_s       = 5'($urandom_range(1, 31));
    t.rs1_s      = 5'($urandom);
    t.rs2_s      = 5'($urandom);
    t.rs1_v      = $urandom;
    t.rs2_v      = $urandom;
    t.regf_we    = 1'b1;
    t.opcode     = OP_ALU;
    t.funct3     = 3'($urandom);
    t.alu_result = $urandom;
    t.mem_addr   = $urandom;
    t.rmask      = 4'd0;
    t.wmask      = 4'd0;
    t.wdata      = $urandom;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t      t;
    int unsigned kind;
    int unsigned sz;
    int unsigned o;
    logic [3:0]  m;
    t    = base_instr();
    kind = $urandom_range(0, 3);
    sz   = $urandom_range(0, 2);
    o    = $urandom_range(0, 3);
    if (sz == 1) o = o & 2;
    if (sz == 2) o = 0;
    m = (sz == 0) ? 4'(1 << o) : (sz == 1) ? 4'(3 << o) : 4'hF;
    case (kind)
      0: begin
        t.rd_s    = 5'($urandom);
        t.regf_we = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) t.opcode = OP_JAL;
      end
      1: begin
        t.opcode     = OP_LOAD;
        t.rd_s       = 5'($urandom);
        t.funct3     = 3'(sz);
        if (sz != 2 && $urandom_range(0, 1) == 1) t.funct3 = 3'(sz + 4);
        t.mem_addr   = ($urandom & 32'hFFFF_FFFC) | o;
        t.alu_result = t.mem_addr;
        t.rmask      = m;
      end
      2: begin
        t.opcode     = OP_STORE;
        t.regf_we    = 1'b0;
        t.funct3     = 3'(sz);
        t.mem_addr   = ($urandom & 32'hFFFF_FFFC) | o;
        t.alu_result = t.mem_addr;
        t.wmask      = m;
      end
      default: begin
        t.valid = 1'b0;
        t.rmask = 4'($urandom);
        t.wmask = 4'($urandom);
      end
    endcase
    return t;
  endfunction

  // Present one instruction, respond after 'delay' cycles when it accesses memory,
  // and check bus, stall and MEM/WB every cycle. Entered and left at posedge+1.
  task automatic issue(input instr_t t, input int delay, input logic [31:0] rdata);
    bit acc;
    acc        = t.valid && (t.rmask != 4'd0 || t.wmask != 4'd0);
    ex_mem_reg = pack_em(t);
    dmem_resp  = 1'b0;
    dmem_rdata = $urandom;
    @(negedge clk);
    if (!acc) begin
      chk_val("idle_stall", 320'(mem_stall), 320'(1'b0));
      chk_val("idle_masks", 320'({dmem_rmask, dmem_wmask}), 320'(8'h00));
      @(posedge clk); #1;
      chk_val("pass_wb", 320'(mem_wb_reg), 320'(exp_wb(t, 1'b0, 32'd0)));
    end else begin
      chk_val("req_stall", 320'(mem_stall), 320'(1'b1));
      chk_val("req_addr", 320'(dmem_addr), 320'(t.mem_addr & 32'hFFFF_FFFC));
      chk_val("req_rmask", 320'(dmem_rmask), 320'(t.rmask));
      chk_val("req_wmask", 320'(dmem_wmask), 320'(t.wmask));
      chk_val("req_wdata", 320'(dmem_wdata), 320'(t.wdata));
      @(posedge clk); #1;
      chk_val("req_wb_valid", 320'(mem_wb_reg[312]), 320'(1'b0));
      for (int k = 1; k < delay; k++) begin
        dmem_rdata = $urandom;
        @(negedge clk);
        chk_val("wait_stall", 320'(mem_stall), 320'(1'b1));
        chk_val("wait_masks", 320'({dmem_rmask, dmem_wmask}), 320'(8'h00));
        @(posedge clk); #1;
        chk_val("wait_wb_valid", 320'(mem_wb_reg[312]), 320'(1'b0));
      end
      dmem_resp  = 1'b1;
      dmem_rdata = rdata;
      @(negedge clk);
      chk_val("resp_stall", 320'(mem_stall), 320'(1'b0));
      chk_val("resp_masks", 320'({dmem_rmask, dmem_wmask}), 320'(8'h00));
      @(posedge clk); #1;
      dmem_resp = 1'b0;
      chk_val("commit_wb", 320'(mem_wb_reg), 320'(exp_wb(t, 1'b1, rdata)));
    end
  endtask

  initial begin
    instr_t t;
    instr_t bub;
    clk        = 1'b0;
    rst_n      = 1'b0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'd0;
    t          = base_instr();
    t.opcode   = OP_LOAD;
    t.rmask    = 4'hF;
    ex_mem_reg = pack_em(t);
    bub        = base_instr();
    bub.valid  = 1'b0;

    // Reset state, with an access presented on the input.
    #3;
    chk_val("rst_wb", 320'(mem_wb_reg), 320'(0));
    chk_val("rst_err", 320'(mem_err), 320'(1'b0));
    chk_val("rst_stall", 320'(mem_stall), 320'(1'b0));
    chk_val("rst_masks", 320'({dmem_rmask, dmem_wmask}), 320'(8'h00));
    @(posedge clk); @(posedge clk); #1;
    ex_mem_reg = pack_em(bub);
    rst_n      = 1'b1;

    // lw with 1-cycle response, then a bubble shows a single commit.
    t = base_instr();
    t.opcode = OP_LOAD; t.funct3 = 3'd2; t.mem_addr = 32'h1000_0004; t.rmask = 4'hF;
    issue(t, 1, 32'hDEAD_BEEF);
    chk_val("lw_rd_v", 320'(mem_wb_reg[135:104]), 320'(32'hDEAD_BEEF));
    chk_val("lw_valid", 320'(mem_wb_reg[312]), 320'(1'b1));
    issue(bub, 1, 32'd0);
    chk_val("lw_once", 320'(mem_wb_reg[312]), 320'(1'b0));

    // lb / lbu at byte offset 3.
    t.funct3 = 3'd0; t.mem_addr = 32'h1000_0003; t.rmask = 4'b1000;
    issue(t, 1, 32'h80FF_FFFF);
    chk_val("lb_rd_v", 320'(mem_wb_reg[135:104]), 320'(32'hFFFF_FF80));
    t.funct3 = 3'd4;
    issue(t, 2, 32'h80FF_FFFF);
    chk_val("lbu_rd_v", 320'(mem_wb_reg[135:104]), 320'(32'h0000_0080));

    // sh at offset 2.
    t = base_instr();
    t.opcode = OP_STORE; t.funct3 = 3'd1; t.regf_we = 1'b0;
    t.mem_addr = 32'h2000_0002; t.wmask = 4'b1100; t.wdata = 32'hABCD_0000;
    issue(t, 1, $urandom);
    chk_val("sh_wdata", 320'(mem_wb_reg[31:0]), 320'(32'hABCD_0000));
    chk_val("sh_rdata", 320'(mem_wb_reg[63:32]), 320'(32'd0));
    chk_val("sh_rd_v", 320'(mem_wb_reg[135:104]), 320'(32'd0));

    // Load with a 4-cycle response.
    t = base_instr();
    t.opcode = OP_LOAD; t.funct3 = 3'd5; t.mem_addr = 32'h3000_0002; t.rmask = 4'b1100;
    issue(t, 4, 32'h9876_5432);
    chk_val("lhu_rd_v", 320'(mem_wb_reg[135:104]), 320'(32'h0000_9876));

    // ALU op, then the same op squashed.
    t = base_instr();
    t.alu_result = 32'd7; t.rd_s = 5'd5;
    issue(t, 1, 32'd0);
    chk_val("add_rd_v", 320'(mem_wb_reg[135:104]), 320'(32'd7));
    t.valid = 1'b0;
    issue(t, 1, 32'd0);
    chk_val("add_squash", 320'(mem_wb_reg[312]), 320'(1'b0));

    // Randomized mix.
    for (int i = 0; i < 300; i++) begin
      issue(rand_instr(), $urandom_range(1, 8), $urandom);
      chk_val("rand_err", 320'(mem_err), 320'(1'b0));
    end

    // Reset in the middle of S_WAIT, then a late response.
    t = base_instr();
    t.opcode = OP_LOAD; t.funct3 = 3'd2; t.mem_addr = 32'h4000_0000; t.rmask = 4'hF;
    ex_mem_reg = pack_em(t);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_val("mid_rst_wb", 320'(mem_wb_reg), 320'(0));
    chk_val("mid_rst_masks", 320'({dmem_rmask, dmem_wmask}), 320'(8'h00));
    @(posedge clk); @(posedge clk); #1;
    chk_val("mid_rst_stall", 320'(mem_stall), 320'(1'b0));
    ex_mem_reg = pack_em(bub);
    rst_n      = 1'b1;
    dmem_resp  = 1'b1;
    dmem_rdata = $urandom;
    @(negedge clk);
    chk_val("stray_stall", 320'(mem_stall), 320'(1'b0));
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    chk_val("stray_wb", 320'(mem_wb_reg), 320'(exp_wb(bub, 1'b0, 32'd0)));
    chk_val("stray_err", 320'(mem_err), 320'(1'b0));
    issue(t, 2, 32'h1234_5678);

    // Watchdog: no response for MAX_WAIT=8 cycles in S_WAIT.
    ex_mem_reg = pack_em(t);
    @(posedge clk); #1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk_val("wd_err", 320'(mem_err), 320'(k >= 8));
      chk_val("wd_stall", 320'(mem_stall), 320'(1'b1));
    end
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    chk_val("wd_commit", 320'(mem_wb_reg), 320'(exp_wb(t, 1'b1, 32'hCAFE_F00D)));
    chk_val("wd_sticky", 320'(mem_err), 320'(1'b1));
    ex_mem_reg = pack_em(bub);
    rst_n = 1'b0;
    #1;
    chk_val("wd_rst_clear", 320'(mem_err), 320'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
